// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// FIFO_TX_PARITY_EN (when defined) adds a parity bit to every frame.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int unsigned DATA_BITS = 8;

    // Frame duration in clk cycles: start + data + parity + stop bits.
    function automatic int unsigned frame_len(input int unsigned cpb,
                                              input int unsigned stop,
                                              input int unsigned par);
        return (1 + DATA_BITS + par + stop) * cpb;
    endfunction

endpackage

// File: rtl/fifo_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
module fifo_tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the sync FIFO and serialises them as UART frames on tx.
// Optional parity bit is enabled by defining FIFO_TX_PARITY_EN.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_enable,
    input  logic        fifo_empty,
    input  logic        fifo_wr_en,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    import fifo_uart_tx_pkg::*;

    tx_state_t  state, state_d;
    logic [7:0] shreg, shreg_d;
    logic [2:0] bit_idx, bit_idx_d;
    logic       blk;
    logic       cnt_inc;
    logic       tx_d;
    logic       tick;
    logic       restart;
`ifdef FIFO_TX_PARITY_EN
    logic       par_q;
`endif

    assign restart    = (state == CAPT) && !blk;
    assign fifo_rd_en = (state == REQ);
    assign busy       = (state != IDLE);

    fifo_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_idx_d = bit_idx;
        cnt_inc   = 1'b0;
        case (state)
            IDLE:  if (tx_enable && !fifo_empty) state_d = REQ;
            REQ:   state_d = CAPT;
            CAPT: begin
                // A read that collided with a write was dropped by the FIFO.
                if (blk) begin
                    state_d = IDLE;
                end else begin
                    shreg_d   = fifo_dout;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: if (tick) state_d = DATA;
            DATA: begin
                if (tick) begin
                    shreg_d   = {1'b0, shreg[7:1]};
                    bit_idx_d = bit_idx + 1'b1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
`ifdef FIFO_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef FIFO_TX_PARITY_EN
            PARITY: if (tick) state_d = STOP;
`endif
            STOP: begin
                if (tick) begin
                    if (bit_idx == 3'(STOP_BITS - 1)) begin
                        bit_idx_d = '0;
                        cnt_inc   = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the next state so it moves exactly on bit boundaries.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shreg_d[0];
`ifdef FIFO_TX_PARITY_EN
            PARITY: tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            shreg     <= '0;
            bit_idx   <= '0;
            blk       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state   <= state_d;
            tx      <= tx_d;
            shreg   <= shreg_d;
            bit_idx <= bit_idx_d;
            if (state == REQ) blk <= fifo_wr_en;
            if (cnt_inc) frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef FIFO_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (state == CAPT) begin
            par_q <= (^fifo_dout) ^ 1'(PARITY_ODD);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with a behavioural byte FIFO.
module tb_fifo_uart_tx;
    import fifo_uart_tx_pkg::*;

    localparam int unsigned CPB  = 4;
    localparam int unsigned STOP_N = 1;
    localparam int unsigned PODD = 0;
`ifdef FIFO_TX_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif
    localparam int NB = 10 + P;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_wr_en = 1'b0;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_rd_en;
    logic        tx;
    logic        busy;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int rd_dbl = 0;
    logic rd_prev = 1'b0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (STOP_N),
        .PARITY_ODD  (PODD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_enable (tx_enable),
        .fifo_empty(fifo_empty),
        .fifo_wr_en(fifo_wr_en),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    // FIFO model: write has priority, a colliding read is dropped.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_wr_en) begin
            q.push_back(8'h3C);
            fifo_dout <= 8'hEE;
        end else if (fifo_rd_en && q.size() > 0) begin
            fifo_dout <= q.pop_front();
        end else if (fifo_wr_en) begin
            q.push_back(8'h3C);
        end
        fifo_empty <= (q.size() == 0);
        if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
        if (fifo_rd_en && rd_prev) rd_dbl <= rd_dbl + 1;
        rd_prev <= fifo_rd_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef FIFO_TX_PARITY_EN
        if (b == 9) return (^d) ^ 1'(PODD);
`endif
        return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tx_enable = 1'b0;
        fifo_wr_en = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Leaves the caller on the negedge of the first start-bit cycle.
    task automatic wait_start(output int idle);
        idle = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (tx == 1'b0) return;
            idle++;
        end
        check("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input logic [7:0] d);
        logic [3:0] s;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                s[c] = tx;
            end
            check($sformatf("byte%02h_bit%0d", d, b), {28'd0, s}, exp_bit(d, b) ? 32'hF : 32'h0);
        end
        check("stop_busy", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        int idle;
        int rb;
        int len;
        logic samp[0:63];

        // reset state
        do_reset();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_cnt", {16'd0, frame_cnt}, 32'd0);

        // single frame 0xA5
        rb = rd_cnt;
        q.push_back(8'hA5);
        tx_enable = 1'b1;
        wait_start(idle);
        check_frame(8'hA5);
        @(negedge clk);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_cnt", {16'd0, frame_cnt}, 32'd1);
        check("t1_rd", rd_cnt - rb, 32'd1);

        // write collides with the read request
        do_reset();
        rb = rd_cnt;
        q.push_back(8'h5A);
        tx_enable = 1'b1;
        idle = 0;
        while (!fifo_rd_en && idle < 50) begin
            @(negedge clk);
            idle++;
        end
        check("t2_req_seen", {31'd0, fifo_rd_en}, 32'd1);
        fifo_wr_en = 1'b1;
        @(negedge clk);
        fifo_wr_en = 1'b0;
        wait_start(idle);
        tx_enable = 1'b0;
        check_frame(8'h5A);
        @(negedge clk);
        check("t2_cnt", {16'd0, frame_cnt}, 32'd1);
        check("t2_rd", rd_cnt - rb, 32'd2);

        // back-to-back frames
        do_reset();
        rb = rd_cnt;
        q.push_back(8'h01);
        q.push_back(8'h02);
        q.push_back(8'h03);
        tx_enable = 1'b1;
        wait_start(idle);
        check_frame(8'h01);
        wait_start(idle);
        check("t3_gap1", idle, 32'd3);
        check_frame(8'h02);
        wait_start(idle);
        check("t3_gap2", idle, 32'd3);
        check_frame(8'h03);
        @(negedge clk);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_cnt", {16'd0, frame_cnt}, 32'd3);
        check("t3_rd", rd_cnt - rb, 32'd3);

        // reset during data bit 3 of byte 0x00
        q.push_back(8'h00);
        wait_start(idle);
        repeat (17) @(negedge clk);
        check("t4_bit3", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("t4_tx", {31'd0, tx}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_rd", {31'd0, fifo_rd_en}, 32'd0);
        check("t4_cnt", {16'd0, frame_cnt}, 32'd0);
        reset = 1'b0;

        // tx_enable dropped during START
        do_reset();
        rb = rd_cnt;
        q.push_back(8'h96);
        q.push_back(8'h69);
        tx_enable = 1'b1;
        wait_start(idle);
        tx_enable = 1'b0;
        check_frame(8'h96);
        repeat (10) @(negedge clk);
        check("t5_rd_low", rd_cnt - rb, 32'd1);
        check("t5_idle", {31'd0, busy}, 32'd0);
        tx_enable = 1'b1;
        @(negedge clk);
        check("t5_resume", {31'd0, fifo_rd_en}, 32'd1);
        wait_start(idle);
        check_frame(8'h69);

        // frame length and parity with byte 0x07
        do_reset();
        q.push_back(8'h07);
        tx_enable = 1'b1;
        wait_start(idle);
        len = 0;
        while (busy && len < 64) begin
            samp[len] = tx;
            len++;
            @(negedge clk);
        end
        check("t6_len", len, frame_len(CPB, STOP_N, P));
        check("t6_bit2", {31'd0, samp[13]}, 32'd1);
        check("t6_bit3", {31'd0, samp[17]}, 32'd0);
        check("t6_bit9", {31'd0, samp[37]}, 32'd1);

        check("rd_double", rd_dbl, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
